// File: rtl/cn0363_phase_data_sync_mc.sv
// cn0363_phase_data_sync_mc: assembles ADC bytes into channel/phase-tagged samples and buffers them in a FWFT FIFO.
module cn0363_phase_data_sync_mc #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_WIDTH      = 24,
  parameter int PHASE_WIDTH     = 32,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int CH_WIDTH        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_has_stat,
  input  logic                   s_axis_sample_valid,
  output logic                   s_axis_sample_ready,
  input  logic [7:0]             s_axis_sample_data,
  input  logic                   conv_done,
  input  logic [PHASE_WIDTH-1:0] phase,
  output logic                   m_axis_valid,
  input  logic                   m_axis_ready,
  output logic [DATA_WIDTH-1:0]  m_axis_sample_data,
  output logic [PHASE_WIDTH-1:0] m_axis_phase_data,
  output logic [CH_WIDTH-1:0]    m_axis_channel,
  output logic                   overflow,
  output logic                   channel_error,
  output logic [15:0]            overflow_count
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam logic [2:0] DBYTES = 3'(DATA_WIDTH / 8);
  localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CH_WIDTH-1:0] ONE_CH = CH_WIDTH'(NUM_CHANNELS > 1 ? 1 : 0);
  localparam logic [DATA_WIDTH-1:0] SIGN_FLIP = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0] cnt, last_idx;
  logic [DATA_WIDTH-1:0] hold, hold_next, assembled;
  logic [PHASE_WIDTH-1:0] phase_hold;
  logic conv_done_d1, synced;
  logic [CH_WIDTH-1:0] expected, exp_inc, exp_nx, ch;
  logic take, last, shift_en, stat_zero, match, acc, err;
  logic [3:0] stat;
  logic st_v, err_q;
  logic [CH_WIDTH-1:0] st_ch;
  logic [DATA_WIDTH-1:0] st_data;
  logic [PHASE_WIDTH-1:0] st_phase;
  logic [AW:0] wp, rp;
  logic full, empty, wr, rd;
  logic [CH_WIDTH-1:0] mem_ch [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PHASE_WIDTH-1:0] mem_phase [DEPTH];
  logic [15:0] ovf_cnt;

  generate
    if (DATA_WIDTH == 8) begin : g_narrow
      assign hold_next = s_axis_sample_data;
    end else begin : g_wide
      assign hold_next = {hold[DATA_WIDTH-9:0], s_axis_sample_data};
    end
  endgenerate

  // A status-mode sample is complete without shifting its final (status) byte in.
  always_comb begin
    last_idx  = DBYTES + 3'(sample_has_stat) - 3'd1;
    take      = s_axis_sample_valid & enable;
    last      = take & (cnt == last_idx);
    shift_en  = take & ~(sample_has_stat & (cnt == last_idx));
    assembled = sample_has_stat ? hold : hold_next;
    stat      = s_axis_sample_data[3:0];
    stat_zero = stat == 4'd0;
    match     = synced & (32'(stat) == 32'(expected));
    exp_inc   = expected == LAST_CH ? '0 : expected + CH_WIDTH'(1);
    acc       = ~sample_has_stat | match | stat_zero;
    err       = sample_has_stat & synced & ~match;
    ch        = (~sample_has_stat | match) ? expected : '0;
    exp_nx    = (~sample_has_stat | match) ? exp_inc : stat_zero ? ONE_CH : expected;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      hold     <= '0;
      expected <= '0;
      synced   <= 1'b0;
      st_v     <= 1'b0;
      err_q    <= 1'b0;
      st_ch    <= '0;
      st_data  <= '0;
      st_phase <= '0;
    end else if (!enable) begin
      cnt      <= '0;
      expected <= '0;
      synced   <= 1'b0;
      st_v     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (take) cnt <= last ? '0 : cnt + 3'd1;
      if (shift_en) hold <= hold_next;
      if (last) expected <= exp_nx;
      synced <= ~sample_has_stat | (last ? acc : synced);
      st_v   <= last & acc;
      err_q  <= last & err;
      if (last) begin
        st_ch    <= ch;
        st_data  <= assembled ^ SIGN_FLIP;
        st_phase <= phase_hold;
      end
    end
  end

  // Phase tracking continues even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_done_d1 <= 1'b0;
      phase_hold   <= '0;
    end else begin
      conv_done_d1 <= conv_done;
      if (conv_done & ~conv_done_d1) phase_hold <= phase;
    end
  end

  assign empty    = wp == rp;
  assign full     = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]);
  assign rd       = ~empty & m_axis_ready;
  assign wr       = st_v & enable & (~full | rd);
  assign overflow = st_v & enable & full & ~rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else if (!enable) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_ch[i]    <= '0;
        mem_data[i]  <= '0;
        mem_phase[i] <= '0;
      end
    end else if (wr) begin
      mem_ch[wp[AW-1:0]]    <= st_ch;
      mem_data[wp[AW-1:0]]  <= st_data;
      mem_phase[wp[AW-1:0]] <= st_phase;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_cnt <= '0;
    else if (overflow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end

  assign s_axis_sample_ready = 1'b1;
  assign m_axis_valid        = ~empty;
  assign m_axis_channel      = mem_ch[rp[AW-1:0]];
  assign m_axis_sample_data  = mem_data[rp[AW-1:0]];
  assign m_axis_phase_data   = mem_phase[rp[AW-1:0]];
  assign channel_error       = err_q;
  assign overflow_count      = ovf_cnt;
endmodule

// File: tb/tb_cn0363_phase_data_sync_mc.sv
// tb_cn0363_phase_data_sync_mc: randomized scenario bench with a queue-based reference model.
module tb_cn0363_phase_data_sync_mc;
  localparam int NCH = 2, DW = 24, PW = 32, CW = 4, DEPTH = 4;

  logic clk = 0, reset = 1, enable = 1, sample_has_stat = 0;
  logic s_valid = 0, s_ready, conv_done = 0, m_axis_ready = 0;
  logic [7:0] s_data = 0;
  logic [PW-1:0] phase = 0;
  logic m_axis_valid, overflow, channel_error;
  logic [DW-1:0] m_data;
  logic [PW-1:0] m_phase_out;
  logic [CW-1:0] m_ch_out;
  logic [15:0] overflow_count;

  typedef struct packed {logic [CW-1:0] ch; logic [DW-1:0] data; logic [PW-1:0] ph;} entry_t;
  entry_t got;
  entry_t exp_q[$];
  int checks = 0, fails = 0;
  int m_ch = 0, m_exp = 0, m_ovf_cnt = 0;
  bit m_synced = 0;
  logic [PW-1:0] m_phase = 0;

  assign got = {m_ch_out, m_data, m_phase_out};

  cn0363_phase_data_sync_mc dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_has_stat(sample_has_stat),
    .s_axis_sample_valid(s_valid), .s_axis_sample_ready(s_ready), .s_axis_sample_data(s_data),
    .conv_done(conv_done), .phase(phase), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_sample_data(m_data), .m_axis_phase_data(m_phase_out), .m_axis_channel(m_ch_out),
    .overflow(overflow), .channel_error(channel_error), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_valid = 1; s_data = b;
    tick();
    s_valid = 0;
  endtask

  task automatic latch_phase(input logic [PW-1:0] p);
    phase = p; conv_done = 1;
    tick();
    conv_done = 0;
    tick();
    m_phase = p;
  endtask

  task automatic send_sample(input logic [DW-1:0] raw, input logic [3:0] stat);
    logic [3:0] junk;
    junk = 4'($urandom);
    send_byte(raw[23:16]);
    send_byte(raw[15:8]);
    send_byte(raw[7:0]);
    if (sample_has_stat) send_byte({junk, stat});
  endtask

  function automatic void model_flush();
    exp_q.delete();
    m_ch = 0; m_exp = 0; m_synced = 0;
  endfunction

  // Channel rules applied to a completed sample; FIFO occupancy is exp_q.size().
  function automatic void model(input logic [DW-1:0] raw, input logic [3:0] stat,
                                output bit acc, output bit err, output bit ovf);
    entry_t e;
    int ch;
    acc = 0; err = 0; ch = 0;
    if (!sample_has_stat) begin
      acc = 1; ch = m_ch; m_ch = (m_ch + 1) % NCH;
    end else if (!m_synced) begin
      if (stat == 0) begin acc = 1; m_synced = 1; m_exp = 1 % NCH; end
    end else if (int'(stat) == m_exp) begin
      acc = 1; ch = m_exp; m_exp = (m_exp + 1) % NCH;
    end else begin
      err = 1;
      if (stat == 0) begin acc = 1; m_exp = 1 % NCH; end
      else m_synced = 0;
    end
    ovf = acc && exp_q.size() == DEPTH;
    if (ovf) m_ovf_cnt = m_ovf_cnt == 65535 ? 65535 : m_ovf_cnt + 1;
    else if (acc) begin
      e.ch = CW'(ch); e.data = raw ^ 24'h800000; e.ph = m_phase;
      exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    checks++; if (m_axis_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", m_axis_valid); end
    checks++; if (got !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", got); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (channel_error !== 1'b0) begin fails++; $display("FAIL reset_chan_err: got %b expected 0", channel_error); end
    checks++; if (overflow_count !== 16'd0) begin fails++; $display("FAIL reset_ovf_count: got %0d expected 0", overflow_count); end
    checks++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    reset = 0;
    tick();
    checks++; if (m_axis_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b expected 0", m_axis_valid); end
  endtask

  task automatic test_no_status();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    logic [PW-1:0] p;
    for (int i = 0; i < 8; i++) begin
      raw = i == 0 ? 24'h800001 : i == 1 ? 24'h7FFFFF : 24'($urandom);
      p = $urandom;
      latch_phase(p);
      send_sample(raw, 4'd0);
      model(raw, 4'd0, acc, err, ovf);
      checks++; if (m_axis_valid !== 1'b0) begin fails++; $display("FAIL nostat_latency1: got %b expected 0", m_axis_valid); end
      tick();
      checks++; if (m_axis_valid !== 1'b1) begin fails++; $display("FAIL nostat_latency2: got %b expected 1", m_axis_valid); end
      checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin fails++; $display("FAIL nostat_entry: got %h expected %h", got, exp_q.size() ? exp_q[0] : entry_t'('0)); end
      if (i < 2) begin
        checks++; if (m_data !== (i == 0 ? 24'h000001 : 24'hFFFFFF) || m_ch_out !== CW'(i) || m_phase_out !== p) begin fails++; $display("FAIL nostat_fixed%0d: got %h expected ch%0d", i, got, i); end
      end
      if (exp_q.size()) void'(exp_q.pop_front());
      m_axis_ready = 1;
      tick();
      m_axis_ready = 0;
      checks++; if (m_axis_valid !== 1'b0) begin fails++; $display("FAIL nostat_pop: got %b expected 0", m_axis_valid); end
    end
  endtask

  task automatic test_phase_coincide();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    logic [PW-1:0] pa, pb;
    pa = $urandom; pb = ~pa;
    raw = 24'($urandom);
    latch_phase(pa);
    send_byte(raw[23:16]);
    send_byte(raw[15:8]);
    phase = pb; conv_done = 1; s_valid = 1; s_data = raw[7:0];
    tick();
    s_valid = 0; conv_done = 0;
    model(raw, 4'd0, acc, err, ovf);
    m_phase = pb;
    tick();
    checks++; if (m_axis_valid !== 1'b1 || m_phase_out !== pa) begin fails++; $display("FAIL coincide_old_phase: got %h expected %h", m_phase_out, pa); end
    checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin fails++; $display("FAIL coincide_entry: got %h expected %h", got, exp_q.size() ? exp_q[0] : entry_t'('0)); end
    if (exp_q.size()) void'(exp_q.pop_front());
    m_axis_ready = 1; tick(); m_axis_ready = 0;
    raw = 24'($urandom);
    send_sample(raw, 4'd0);
    model(raw, 4'd0, acc, err, ovf);
    tick();
    checks++; if (exp_q.size() == 0 || got !== exp_q[0] || m_phase_out !== pb) begin fails++; $display("FAIL coincide_new_phase: got %h expected %h", got, exp_q.size() ? exp_q[0] : entry_t'('0)); end
    if (exp_q.size()) void'(exp_q.pop_front());
    m_axis_ready = 1; tick(); m_axis_ready = 0;
  endtask

  task automatic test_back_to_back();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    int popped = 0;
    enable = 0; sample_has_stat = 0;
    tick();
    enable = 1; model_flush();
    latch_phase($urandom);
    m_axis_ready = 1;
    for (int s = 0; s < 14; s++) begin
      raw = 24'($urandom);
      for (int b = 0; b < 3 + (s >= 10 ? 2 : 0); b++) begin
        s_valid = s < 10; s_data = raw[23 - 8 * (b % 3) -: 8];
        tick();
        if (s < 10 && b == 2) model(raw, 4'd0, acc, err, ovf);
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        if (m_axis_valid) begin
          checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin fails++; $display("FAIL b2b_entry: got %h expected %h", got, exp_q.size() ? exp_q[0] : entry_t'('0)); end
          if (exp_q.size()) void'(exp_q.pop_front());
          popped++;
        end
      end
    end
    s_valid = 0; m_axis_ready = 0;
    checks++; if (popped != 10 || exp_q.size() != 0) begin fails++; $display("FAIL b2b_count: got %0d expected 10", popped); end
  endtask

  task automatic test_status();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    logic [3:0] stats[8] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd3, 4'd1, 4'd0};
    enable = 0; sample_has_stat = 1;
    tick();
    enable = 1; model_flush();
    for (int i = 0; i < 8; i++) begin
      raw = 24'($urandom);
      latch_phase($urandom);
      send_sample(raw, stats[i]);
      model(raw, stats[i], acc, err, ovf);
      checks++; if (channel_error !== err) begin fails++; $display("FAIL stat_err%0d: got %b expected %b", i, channel_error, err); end
      tick();
      checks++; if (channel_error !== 1'b0) begin fails++; $display("FAIL stat_err_width%0d: got %b expected 0", i, channel_error); end
      checks++; if (m_axis_valid !== acc) begin fails++; $display("FAIL stat_accept%0d: got %b expected %b", i, m_axis_valid, acc); end
      if (acc) begin
        checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin fails++; $display("FAIL stat_entry%0d: got %h expected %h", i, got, exp_q.size() ? exp_q[0] : entry_t'('0)); end
        if (exp_q.size()) void'(exp_q.pop_front());
        m_axis_ready = 1; tick(); m_axis_ready = 0;
      end
    end
  endtask

  task automatic test_overflow();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    enable = 0; sample_has_stat = 0;
    tick();
    enable = 1; model_flush();
    for (int i = 0; i < 6; i++) begin
      raw = 24'($urandom);
      latch_phase($urandom);
      send_sample(raw, 4'd0);
      model(raw, 4'd0, acc, err, ovf);
      checks++; if (overflow !== ovf) begin fails++; $display("FAIL ovf_pulse%0d: got %b expected %b", i, overflow, ovf); end
      tick();
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_width%0d: got %b expected 0", i, overflow); end
      checks++; if (!m_axis_valid || got !== exp_q[0]) begin fails++; $display("FAIL ovf_head_stable%0d: got %h expected %h", i, got, exp_q[0]); end
    end
    checks++; if (overflow_count !== 16'(m_ovf_cnt) || m_ovf_cnt != 2) begin fails++; $display("FAIL ovf_count: got %0d expected 2", overflow_count); end
    m_axis_ready = 1;
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      checks++; if (!m_axis_valid || got !== exp_q[0]) begin fails++; $display("FAIL ovf_drain%0d: got %h expected %h", i, got, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    m_axis_ready = 0;
    checks++; if (m_axis_valid !== 1'b0 || exp_q.size() != 0) begin fails++; $display("FAIL ovf_empty: got %b expected 0", m_axis_valid); end
  endtask

  task automatic test_full_pop();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    for (int i = 0; i < DEPTH; i++) begin
      raw = 24'($urandom);
      latch_phase($urandom);
      send_sample(raw, 4'd0);
      model(raw, 4'd0, acc, err, ovf);
    end
    tick();
    raw = 24'($urandom);
    latch_phase($urandom);
    send_sample(raw, 4'd0);
    checks++; if (got !== exp_q[0]) begin fails++; $display("FAIL fullpop_head: got %h expected %h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    m_axis_ready = 1;
    model(raw, 4'd0, acc, err, ovf);
    #1;
    checks++; if (overflow !== 1'b0 || ovf) begin fails++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
    tick();
    m_axis_ready = 0;
    checks++; if (overflow_count !== 16'(m_ovf_cnt)) begin fails++; $display("FAIL fullpop_count: got %0d expected %0d", overflow_count, m_ovf_cnt); end
    m_axis_ready = 1;
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) begin
      checks++; if (!m_axis_valid || got !== exp_q[0]) begin fails++; $display("FAIL fullpop_drain%0d: got %h expected %h", i, got, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    m_axis_ready = 0;
    checks++; if (m_axis_valid !== 1'b0 || exp_q.size() != 0) begin fails++; $display("FAIL fullpop_empty: got %b expected 0", m_axis_valid); end
  endtask

  task automatic test_reset_mid();
    bit acc, err, ovf;
    logic [DW-1:0] raw;
    for (int i = 0; i < 2; i++) begin
      raw = 24'($urandom);
      latch_phase($urandom);
      send_sample(raw, 4'd0);
      model(raw, 4'd0, acc, err, ovf);
    end
    send_byte(8'hAA);
    send_byte(8'h55);
    reset = 1;
    #1;
    checks++; if (m_axis_valid !== 1'b0 || overflow_count !== 16'd0) begin fails++; $display("FAIL rst_mid_async: got %b/%0d expected 0/0", m_axis_valid, overflow_count); end
    tick();
    reset = 0;
    model_flush(); m_ovf_cnt = 0; m_phase = '0;
    raw = 24'h800005;
    latch_phase($urandom);
    send_sample(raw, 4'd0);
    model(raw, 4'd0, acc, err, ovf);
    tick();
    checks++; if (!m_axis_valid || got !== exp_q[0] || m_data !== 24'h000005 || m_ch_out !== 4'd0) begin fails++; $display("FAIL rst_mid_first: got %h expected %h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    m_axis_ready = 1; tick(); m_axis_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      raw = 24'($urandom);
      latch_phase($urandom);
      send_sample(raw, 4'd0);
      model(raw, 4'd0, acc, err, ovf);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    checks++; if (m_axis_valid !== 1'b1) begin fails++; $display("FAIL en_full: got %b expected 1", m_axis_valid); end
    enable = 0;
    tick();
    enable = 1; model_flush();
    checks++; if (m_axis_valid !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL en_flush: got %b expected 0", m_axis_valid); end
    raw = 24'($urandom);
    latch_phase($urandom);
    send_sample(raw, 4'd0);
    model(raw, 4'd0, acc, err, ovf);
    tick();
    checks++; if (!m_axis_valid || got !== exp_q[0] || m_ch_out !== 4'd0) begin fails++; $display("FAIL en_next_ch0: got %h expected %h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    m_axis_ready = 1; tick(); m_axis_ready = 0;
    checks++; if (m_axis_valid !== 1'b0) begin fails++; $display("FAIL en_final_empty: got %b expected 0", m_axis_valid); end
  endtask

  initial begin
    test_reset();
    test_no_status();
    test_phase_coincide();
    test_back_to_back();
    test_status();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
